// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: funct codes, FSM states and
// the operation kinds that select how FIX commits HI/LO.
package mdu_pkg;

  localparam int MDU_DATA_W = 32;

  localparam logic [5:0] FUNC_MFHI  = 6'h10;
  localparam logic [5:0] FUNC_MTHI  = 6'h11;
  localparam logic [5:0] FUNC_MFLO  = 6'h12;
  localparam logic [5:0] FUNC_MTLO  = 6'h13;
  localparam logic [5:0] FUNC_MULT  = 6'h18;
  localparam logic [5:0] FUNC_MULTU = 6'h19;
  localparam logic [5:0] FUNC_DIV   = 6'h1A;
  localparam logic [5:0] FUNC_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_MUL = 2'd0,
    OP_DIV = 2'd1,
    OP_DBZ = 2'd2
  } op_e;

endpackage

// File: rtl/mdu_divider.sv
// Unsigned iterative restoring divider: one quotient bit per cycle, DATA_W cycles.
// Operands are magnitudes; sign correction is done by the caller.
module mdu_divider
  import mdu_pkg::*;
#(
  parameter int DATA_W = MDU_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [DATA_W-1:0] i_dividend,
  input  logic [DATA_W-1:0] i_divisor,
  output logic              o_last,
  output logic [DATA_W-1:0] o_quotient,
  output logic [DATA_W-1:0] o_remainder
);
  localparam int CNT_W = $clog2(DATA_W) + 1;

  logic              busy_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] quo_q;
  logic [DATA_W-1:0] dvs_q;

  logic [DATA_W:0]   rem_sh;
  logic [DATA_W:0]   trial;
  logic              ge;

  // Shift the next dividend bit into the partial remainder and try a subtract.
  assign rem_sh = {rem_q, quo_q[DATA_W-1]};
  assign trial  = rem_sh - {1'b0, dvs_q};
  assign ge     = ~trial[DATA_W];
  assign o_last = busy_q && (cnt_q == CNT_W'(DATA_W - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (i_abort) begin
      busy_q <= 1'b0;
    end else if (i_start) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
    end else if (busy_q) begin
      busy_q <= !o_last;
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_start) begin
      rem_q <= '0;
      quo_q <= i_dividend;
      dvs_q <= i_divisor;
    end else if (busy_q) begin
      rem_q <= ge ? trial[DATA_W-1:0] : rem_sh[DATA_W-1:0];
      quo_q <= {quo_q[DATA_W-2:0], ge};
    end
  end

  assign o_quotient  = quo_q;
  assign o_remainder = rem_q;

endmodule

// File: rtl/mdu_unit.sv
// MIPS execute-stage multiply/divide unit owning HI/LO, with ready/valid stall.
// Optional MDU_EARLY_OUT_EN: multiply leaves for FIX once remaining multiplier bits are zero.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int DATA_W   = MDU_DATA_W,
  parameter int MUL_STEP = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [5:0]        i_func,
  input  logic [DATA_W-1:0] i_op_a,
  input  logic [DATA_W-1:0] i_op_b,
  input  logic              i_flush,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_result,
  output logic              o_result_valid,
  output logic              o_done,
  output logic              o_div_by_zero,
  output logic              o_unknown_func
);
  localparam int MUL_CYC = DATA_W / MUL_STEP;
  localparam int CNT_W   = $clog2(DATA_W) + 1;

  function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  function automatic logic [2*DATA_W-1:0] neg_2w(input logic [2*DATA_W-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic sgn);
    return neg_w(v, sgn && v[DATA_W-1]);
  endfunction

  function automatic logic [2*DATA_W-1:0] mul_acc(input logic [2*DATA_W-1:0] acc,
                                                   input logic [2*DATA_W-1:0] mc,
                                                   input logic [MUL_STEP-1:0] bits);
    logic [2*DATA_W-1:0] s;
    s = acc;
    for (int k = 0; k < MUL_STEP; k++) begin
      if (bits[k]) s = s + (mc << k);
    end
    return s;
  endfunction

  state_e              state_q, state_d;
  logic                ready;
  logic                accept;
  logic                commit;

  logic                is_mfhi, is_mflo, is_mthi, is_mtlo;
  logic                is_mul, is_div, is_signed, known;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic                b_zero;

  logic [2*DATA_W-1:0] acc_q;
  logic [2*DATA_W-1:0] mcand_q;
  logic [DATA_W-1:0]   mplier_q;
  logic [DATA_W-1:0]   mplier_nxt;
  logic [CNT_W-1:0]    cnt_q;
  logic                neg_q, rneg_q;
  op_e                 op_q;
  logic [DATA_W-1:0]   opa_q;

  logic                mul_last, mul_skip;
  logic                div_start, div_last;
  logic [DATA_W-1:0]   div_quo, div_rem;
  logic [DATA_W-1:0]   hi_fix, lo_fix;

  logic [DATA_W-1:0]   hi_q, lo_q;
  logic [DATA_W-1:0]   result_q;
  logic                result_vld_q, done_q, dbz_q;

  assign is_mfhi   = (i_func == FUNC_MFHI);
  assign is_mflo   = (i_func == FUNC_MFLO);
  assign is_mthi   = (i_func == FUNC_MTHI);
  assign is_mtlo   = (i_func == FUNC_MTLO);
  assign is_mul    = (i_func == FUNC_MULT) || (i_func == FUNC_MULTU);
  assign is_div    = (i_func == FUNC_DIV)  || (i_func == FUNC_DIVU);
  assign is_signed = (i_func == FUNC_MULT) || (i_func == FUNC_DIV);
  assign known     = is_mfhi || is_mflo || is_mthi || is_mtlo || is_mul || is_div;

  assign a_mag  = mag(i_op_a, is_signed);
  assign b_mag  = mag(i_op_b, is_signed);
  assign b_zero = (i_op_b == '0);

  assign accept    = i_valid && ready && !i_flush;
  assign commit    = (state_q == ST_FIX) && !i_flush;
  assign div_start = accept && is_div && !b_zero;

  assign mplier_nxt = mplier_q >> MUL_STEP;

`ifdef MDU_EARLY_OUT_EN
  assign mul_last = (cnt_q == '0) || (mplier_nxt == '0);
  assign mul_skip = (b_mag == '0);
`else
  assign mul_last = (cnt_q == '0);
  assign mul_skip = 1'b0;
`endif

  mdu_divider #(
    .DATA_W (DATA_W)
  ) u_div (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (div_start),
    .i_abort     (i_flush),
    .i_dividend  (a_mag),
    .i_divisor   (b_mag),
    .o_last      (div_last),
    .o_quotient  (div_quo),
    .o_remainder (div_rem)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && is_mul)      state_d = mul_skip ? ST_FIX : ST_MUL;
        else if (accept && is_div) state_d = b_zero ? ST_FIX : ST_DIV;
      end
      ST_MUL: begin
        if (i_flush)       state_d = ST_IDLE;
        else if (mul_last) state_d = ST_FIX;
      end
      ST_DIV: begin
        if (i_flush)       state_d = ST_IDLE;
        else if (div_last) state_d = ST_FIX;
      end
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready          = (state_q == ST_IDLE);
    o_unknown_func = i_valid && !known;
  end

  // Working registers: loaded at accept, advanced while MUL runs; never reset.
  always_ff @(posedge i_clk) begin
    if (accept && is_mul) begin
      acc_q    <= '0;
      mcand_q  <= {{DATA_W{1'b0}}, a_mag};
      mplier_q <= b_mag;
      cnt_q    <= CNT_W'(MUL_CYC - 1);
      neg_q    <= is_signed && (i_op_a[DATA_W-1] ^ i_op_b[DATA_W-1]);
      op_q     <= OP_MUL;
    end else if (accept && is_div) begin
      neg_q    <= is_signed && (i_op_a[DATA_W-1] ^ i_op_b[DATA_W-1]);
      rneg_q   <= is_signed && i_op_a[DATA_W-1];
      opa_q    <= i_op_a;
      op_q     <= b_zero ? OP_DBZ : OP_DIV;
    end else if (state_q == ST_MUL) begin
      acc_q    <= mul_acc(acc_q, mcand_q, mplier_q[MUL_STEP-1:0]);
      mcand_q  <= mcand_q << MUL_STEP;
      mplier_q <= mplier_nxt;
      cnt_q    <= cnt_q - 1'b1;
    end
  end

  always_comb begin
    hi_fix = '0;
    lo_fix = '0;
    unique case (op_q)
      OP_MUL:  {hi_fix, lo_fix} = neg_2w(acc_q, neg_q);
      OP_DIV: begin
        hi_fix = neg_w(div_rem, rneg_q);
        lo_fix = neg_w(div_quo, neg_q);
      end
      default: begin
        hi_fix = opa_q;
        lo_fix = '1;
      end
    endcase
  end

  // Architectural HI/LO and registered outputs; FIX commit is suppressed by flush.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hi_q         <= '0;
      lo_q         <= '0;
      result_q     <= '0;
      result_vld_q <= 1'b0;
      done_q       <= 1'b0;
      dbz_q        <= 1'b0;
    end else begin
      result_vld_q <= 1'b0;
      done_q       <= 1'b0;
      dbz_q        <= 1'b0;
      if (accept) begin
        if (is_mfhi) begin
          result_q     <= hi_q;
          result_vld_q <= 1'b1;
        end
        if (is_mflo) begin
          result_q     <= lo_q;
          result_vld_q <= 1'b1;
        end
        if (is_mthi) hi_q <= i_op_a;
        if (is_mtlo) lo_q <= i_op_a;
      end
      if (commit) begin
        hi_q   <= hi_fix;
        lo_q   <= lo_fix;
        done_q <= 1'b1;
        dbz_q  <= (op_q == OP_DBZ);
      end
    end
  end

  assign o_ready        = ready;
  assign o_result       = result_q;
  assign o_result_valid = result_vld_q;
  assign o_done         = done_q;
  assign o_div_by_zero  = dbz_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed self-checking bench for mdu_unit (DATA_W=32, MUL_STEP=1).
module tb_mdu_unit;
  import mdu_pkg::*;

`ifdef MDU_EARLY_OUT_EN
  localparam int LAT_FULL   = 33;
  localparam int LAT_7X3    = 3;
  localparam int LAT_N2X3   = 3;
  localparam int FLUSH_EDGE = 2;
`else
  localparam int LAT_FULL   = 33;
  localparam int LAT_7X3    = 33;
  localparam int LAT_N2X3   = 33;
  localparam int FLUSH_EDGE = 10;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [5:0]  func;
  logic [31:0] op_a, op_b;
  logic        flush;
  logic        ready;
  logic [31:0] result;
  logic        result_valid, done, dbz, unknown;

  int checks = 0;
  int errors = 0;

  mdu_unit #(.DATA_W(32), .MUL_STEP(1)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_valid        (valid),
    .i_func         (func),
    .i_op_a         (op_a),
    .i_op_b         (op_b),
    .i_flush        (flush),
    .o_ready        (ready),
    .o_result       (result),
    .o_result_valid (result_valid),
    .o_done         (done),
    .o_div_by_zero  (dbz),
    .o_unknown_func (unknown)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept an op at edge 0 and return the edge index at which o_done is seen.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    valid = 1'b1; func = f; op_a = a; op_b = b;
    step();
    valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic read_reg(input logic [5:0] f, output logic [31:0] v, output logic vld);
    valid = 1'b1; func = f;
    step();
    valid = 1'b0;
    v = result;
    vld = result_valid;
  endtask

  task automatic write_reg(input logic [5:0] f, input logic [31:0] v);
    valid = 1'b1; func = f; op_a = v;
    step();
    valid = 1'b0;
  endtask

  initial begin
    int          lat;
    int          hits;
    int          rdy_early;
    int          done_k;
    int          rv_k;
    logic [31:0] v;
    logic        vld;

    rst_n = 1'b0; valid = 1'b0; func = '0; op_a = '0; op_b = '0; flush = 1'b0;
    step(); step();
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_dbz", dbz, 0);
    rst_n = 1'b1;
    step();
    read_reg(FUNC_MFHI, v, vld);
    chk("rst_hi", v, 32'h0);
    chk("rst_hi_vld", vld, 1);

    // MULTU all-ones squared
    run_op(FUNC_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    chk("multu_lat", lat, LAT_FULL);
    chk("multu_dbz", dbz, 0);
    chk("multu_ready_after", ready, 1);
    read_reg(FUNC_MFHI, v, vld);
    chk("multu_hi", v, 32'hFFFF_FFFE);
    chk("multu_hi_vld", vld, 1);
    step();
    chk("mfhi_pulse_clear", result_valid, 0);
    read_reg(FUNC_MFLO, v, vld);
    chk("multu_lo", v, 32'h0000_0001);

    // DIV -7 / 2
    run_op(FUNC_DIV, 32'hFFFF_FFF9, 32'd2, lat);
    chk("div_lat", lat, 33);
    read_reg(FUNC_MFLO, v, vld);
    chk("div_lo", v, 32'hFFFF_FFFD);
    read_reg(FUNC_MFHI, v, vld);
    chk("div_hi", v, 32'hFFFF_FFFF);

    // DIV overflow case
    run_op(FUNC_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    chk("divovf_lat", lat, 33);
    chk("divovf_dbz", dbz, 0);
    read_reg(FUNC_MFLO, v, vld);
    chk("divovf_lo", v, 32'h8000_0000);
    read_reg(FUNC_MFHI, v, vld);
    chk("divovf_hi", v, 32'h0);

    // DIVU by zero
    run_op(FUNC_DIVU, 32'd5, 32'd0, lat);
    chk("dbz_lat", lat, 1);
    chk("dbz_flag", dbz, 1);
    chk("dbz_ready", ready, 1);
    step();
    chk("dbz_flag_clear", dbz, 0);
    read_reg(FUNC_MFHI, v, vld);
    chk("dbz_hi", v, 32'd5);
    read_reg(FUNC_MFLO, v, vld);
    chk("dbz_lo", v, 32'hFFFF_FFFF);

    // MTLO then MULT flushed in flight
    write_reg(FUNC_MTLO, 32'h1234);
    valid = 1'b1; func = FUNC_MULT; op_a = 32'd3; op_b = 32'd4;
    step();
    valid = 1'b0;
    hits = 0;
    for (int k = 1; k <= FLUSH_EDGE; k++) begin
      if (k == FLUSH_EDGE) flush = 1'b1;
      step();
      if (done) hits++;
    end
    flush = 1'b0;
    chk("flush_ready", ready, 1);
    for (int k = 0; k < 40; k++) begin
      step();
      if (done) hits++;
    end
    chk("flush_no_done", hits, 0);
    read_reg(FUNC_MFLO, v, vld);
    chk("flush_lo", v, 32'h1234);
    read_reg(FUNC_MFHI, v, vld);
    chk("flush_hi", v, 32'd5);

    // Flush in IDLE blocks acceptance
    valid = 1'b1; func = FUNC_MTHI; op_a = 32'hDEAD_BEEF; flush = 1'b1;
    step();
    valid = 1'b0; flush = 1'b0;
    read_reg(FUNC_MFHI, v, vld);
    chk("idle_flush_hi", v, 32'd5);

    // MFHI held during MULT -2 x 3
    valid = 1'b1; func = FUNC_MULT; op_a = 32'hFFFF_FFFE; op_b = 32'd3;
    step();
    func = FUNC_MFHI;
    rdy_early = 0; done_k = -1; rv_k = -1; v = '0;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (done) done_k = k;
      if (done_k < 0 && ready) rdy_early++;
      if (result_valid) begin
        rv_k = k;
        v = result;
        break;
      end
    end
    valid = 1'b0;
    chk("stall_ready_low", rdy_early, 0);
    chk("stall_done_edge", done_k, LAT_N2X3);
    chk("stall_mfhi_edge", rv_k, LAT_N2X3 + 1);
    chk("stall_mfhi_val", v, 32'hFFFF_FFFF);
    read_reg(FUNC_MFLO, v, vld);
    chk("stall_lo", v, 32'hFFFF_FFFA);

    // MULTU 7 x 3
    run_op(FUNC_MULTU, 32'd7, 32'd3, lat);
    chk("m7x3_lat", lat, LAT_7X3);
    read_reg(FUNC_MFLO, v, vld);
    chk("m7x3_lo", v, 32'd21);
    read_reg(FUNC_MFHI, v, vld);
    chk("m7x3_hi", v, 32'd0);

    // Signed MULT most-negative x -1
    run_op(FUNC_MULT, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    read_reg(FUNC_MFHI, v, vld);
    chk("mneg_hi", v, 32'h0);
    read_reg(FUNC_MFLO, v, vld);
    chk("mneg_lo", v, 32'h8000_0000);

    // Unknown funct: combinational flag, accepted as a no-op
    valid = 1'b1; func = 6'h3F;
    #1;
    chk("unknown_flag", unknown, 1);
    step();
    valid = 1'b0;
    #1;
    chk("unknown_clear", unknown, 0);
    chk("unknown_ready", ready, 1);
    chk("unknown_no_done", done, 0);

    // MTHI round trip
    write_reg(FUNC_MTHI, 32'hABCD_0123);
    read_reg(FUNC_MFHI, v, vld);
    chk("mthi_hi", v, 32'hABCD_0123);

    // Asynchronous reset mid-operation
    valid = 1'b1; func = FUNC_MULTU; op_a = 32'd9; op_b = 32'hFFFF_0000;
    step();
    valid = 1'b0;
    step(); step();
    chk("midop_busy", ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ready", ready, 1);
    step();
    rst_n = 1'b1;
    hits = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (done) hits++;
    end
    chk("rst_midop_no_done", hits, 0);
    read_reg(FUNC_MFHI, v, vld);
    chk("rst_midop_hi", v, 32'h0);
    read_reg(FUNC_MFLO, v, vld);
    chk("rst_midop_lo", v, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
